load_store_unit: RTL

Memory-access stage placed directly downstream of the execution stage. It consumes the execution stage's ALU result as the effective address, together with the store data and funct3, and performs one byte-, halfword- or word-wide load or store over a valid/ready data-memory port. It stalls the pipeline until the access completes, aligns and sign- or zero-extends load data, and reports misaligned, illegal-funct3, bus-error and timeout faults.

---
 rtl/load_store_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-access stage: aligned byte/half/word loads and stores
// over a valid/ready data port, with fault reporting.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_out,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  fn3,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_strb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt;
  logic [2:0]  fn3_q;
  logic [1:0]  off_q;
  logic        fault_q;
  logic        access, illegal, misal, timeout_hit;
  logic [31:0] wdata_c, sh_data, ext_data;
  logic [3:0]  strb_c;

  assign access      = mem_read | mem_write;
  assign timeout_hit = (cnt == TO_LAST);

  // Decode width/sign legality and natural alignment of the new access
  always_comb begin
    illegal = 1'b1;
    case (fn3)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = mem_write;
      default:                illegal = 1'b1;
    endcase
    misal = ((fn3[1:0] == 2'b01) && alu_out[0]) ||
            ((fn3[1:0] == 2'b10) && (alu_out[1:0] != 2'b00));
  end

  // Replicate store data across lanes and pick byte enables
  always_comb begin
    wdata_c = rs2_data;
    strb_c  = 4'b1111;
    case (fn3[1:0])
      2'b00: begin
        wdata_c = {4{rs2_data[7:0]}};
        strb_c  = 4'b0001 << alu_out[1:0];
      end
      2'b01: begin
        wdata_c = {2{rs2_data[15:0]}};
        strb_c  = 4'b0011 << {alu_out[1], 1'b0};
      end
      default: begin
        wdata_c = rs2_data;
        strb_c  = 4'b1111;
      end
    endcase
  end

  // Shift the addressed lane down and extend to 32 bits
  always_comb begin
    sh_data = dmem_rdata >> {off_q, 3'b000};
    case (fn3_q)
      3'b000:  ext_data = {{24{sh_data[7]}}, sh_data[7:0]};
      3'b001:  ext_data = {{16{sh_data[15]}}, sh_data[15:0]};
      3'b100:  ext_data = {24'd0, sh_data[7:0]};
      3'b101:  ext_data = {16'd0, sh_data[15:0]};
      default: ext_data = sh_data;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state selection
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (access)
          state_nx = (illegal || misal) ? DONE : REQ;
      end
      REQ: begin
        if (dmem_ready || timeout_hit)
          state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    stall      = !reset &&
                 (((state == IDLE) && access) || (state == REQ));
    dmem_req   = (state == REQ);
    load_valid = (state == DONE) && !fault_q && !dmem_we;
    fault      = (state == DONE) && fault_q;
  end

  // Request registers, wait counter and response capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      fn3_q       <= '0;
      off_q       <= '0;
      fault_q     <= 1'b0;
      fault_cause <= '0;
      load_data   <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      dmem_strb   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            cnt        <= '0;
            fn3_q      <= fn3;
            off_q      <= alu_out[1:0];
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_out[31:2], 2'b00};
            dmem_wdata <= mem_write ? wdata_c : '0;
            dmem_strb  <= mem_write ? strb_c : 4'b0000;
            load_data  <= '0;
            fault_q    <= illegal || misal;
            if (illegal)    fault_cause <= 2'b00;
            else if (misal) fault_cause <= 2'b01;
          end
        end
        REQ: begin
          if (dmem_ready) begin
            fault_q   <= dmem_err;
            load_data <= (!dmem_we && !dmem_err) ? ext_data : '0;
            if (dmem_err) fault_cause <= 2'b10;
          end else if (timeout_hit) begin
            fault_q     <= 1'b1;
            fault_cause <= 2'b11;
            load_data   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
